// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch resolution controller.
//   - ctr_e    : 2-bit predictor counter encodings (SNT/WNT/WT/ST)
//   - fsm_e    : controller FSM states (IDLE/TRACK/FULL/RECOVER)
//   - PCSEL_*  : PC-mux select codes used by the fetch stage
//   - sat_update(): saturating 2-bit counter step
package branch_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        TRACK   = 2'b01,
        FULL    = 2'b10,
        RECOVER = 2'b11
    } fsm_e;

    localparam logic [1:0] PCSEL_PC4 = 2'b00;
    localparam logic [1:0] PCSEL_TGT = 2'b01;
    localparam logic [1:0] PCSEL_RBK = 2'b10;

    // Step is done one bit wider so both overflow (3+1=4) and underflow
    // (0-1 wraps to 3'b111) show up in bit 2, then clamp to the rail.
    function automatic logic [1:0] sat_update(input logic [1:0] st, input logic taken);
        logic [2:0] wide;
        wide = taken ? ({1'b0, st} + 3'd1) : ({1'b0, st} - 3'd1);
        if (wide[2])
            return taken ? CTR_ST : CTR_SNT;
        return wide[1:0];
    endfunction

endpackage

// File: rtl/branch_inflight_fifo.sv
// branch_inflight_fifo: DEPTH x W queue of in-flight branch predictions.
// Ports:
//   clk_i, rst_i (async active-low)
//   push_i/din_i   : append an entry
//   pop_i          : drop the head entry
//   flush_i        : discard every entry (overrides push/pop)
//   dout_o         : head entry, read combinationally so the resolving
//                    branch can be compared in the same cycle
//   full_o, empty_o, count_o : occupancy
// Push while full is only legal together with a pop (caller guarantees).
module branch_inflight_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 33
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i)
            mem_q[wr_q] <= din_i;
    end

    // Pointers are log2(DEPTH) wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: tracks 2-bit predictor decisions from ID to EX,
// issues the predictor update on resolution, and requests rollback/flush
// on a misprediction.
// Optional feature macro: BRANCH_STATS_EN (adds stat_br_o / stat_mis_o).
// Ports:
//   clk_i, rst_i (async active-low), stall_i
//   id_branch_i, state_i, id_target_i, id_pc4_i : prediction made in ID
//   ex_valid_i, ex_taken_i                       : oldest branch resolves
//   update_o/update_valid_o : predictor load (registered)
//   rbk_o/rbk_addr_o/flush_o: misprediction recovery (registered pulse)
//   stall_req_o             : queue full with a new ID branch waiting
//   err_o                   : sticky, resolve with nothing in flight
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          id_branch_i,
    input  logic [1:0]    state_i,
    input  logic [AW-1:0] id_target_i,
    input  logic [AW-1:0] id_pc4_i,
    input  logic          ex_valid_i,
    input  logic          ex_taken_i,
    output logic [1:0]    update_o,
    output logic          update_valid_o,
    output logic          rbk_o,
    output logic [AW-1:0] rbk_addr_o,
    output logic          flush_o,
    output logic          stall_req_o,
`ifdef BRANCH_STATS_EN
    output logic [31:0]   stat_br_o,
    output logic [31:0]   stat_mis_o,
`endif
    output logic          err_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    fsm_e          state_q, state_d;
    logic [AW:0]   head, entry;
    logic          full, empty;
    logic [CW-1:0] count, count_next;
    logic          pop, mis, pop_ok, push, in_recover;

    logic [1:0]    update_q;
    logic          update_valid_q, rbk_q, flush_q, err_q;
    logic [AW-1:0] rbk_addr_q;

    // Entry layout: {pred, alt}; alt is the path we did NOT predict.
    assign entry = {state_i[1], (state_i[1] ? id_pc4_i : id_target_i)};

    assign in_recover = (state_q == RECOVER);
    assign pop        = ex_valid_i & ~stall_i & ~empty;
    assign mis        = pop & (ex_taken_i != head[AW]);
    assign pop_ok     = pop & ~mis;
    // A correct pop frees a slot this cycle, so a full queue may still
    // accept the waiting ID branch. A mispredict kills the wrong-path push.
    assign push = id_branch_i & ~stall_i & ~in_recover & ~mis & (~full | pop_ok);

    assign count_next = mis ? '0 : (count + CW'(push) - CW'(pop_ok));

    branch_inflight_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop_ok),
        .flush_i (mis),
        .din_i   (entry),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        stall_req_o = 1'b0;
        if (state_q == FULL)
            stall_req_o = id_branch_i & ~pop_ok;
        if (!stall_i) begin
            if (mis)
                state_d = RECOVER;
            else if (in_recover || count_next == '0)
                state_d = IDLE;
            else if (count_next == CW'(DEPTH))
                state_d = FULL;
            else
                state_d = TRACK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            update_q       <= CTR_ST;
            update_valid_q <= 1'b0;
            rbk_q          <= 1'b0;
            rbk_addr_q     <= '0;
            flush_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            update_valid_q <= pop;
            rbk_q          <= mis;
            flush_q        <= mis;
            if (pop)
                update_q <= sat_update(state_i, ex_taken_i);
            if (mis)
                rbk_addr_q <= head[AW-1:0];
            if (ex_valid_i && !stall_i && empty)
                err_q <= 1'b1;
        end
    end

    assign update_o       = update_q;
    assign update_valid_o = update_valid_q;
    assign rbk_o          = rbk_q;
    assign rbk_addr_o     = rbk_addr_q;
    assign flush_o        = flush_q;
    assign err_o          = err_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (pop && stat_br_q != '1)
                stat_br_q <= stat_br_q + 32'd1;
            if (mis && stat_mis_q != '1)
                stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_br_o  = stat_br_q;
    assign stat_mis_o = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
    localparam int DEPTH = 2;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          stall_i = 1'b0, id_branch_i = 1'b0;
    logic [1:0]    state_i = 2'b00;
    logic [AW-1:0] id_target_i = '0, id_pc4_i = '0;
    logic          ex_valid_i = 1'b0, ex_taken_i = 1'b0;
    logic [1:0]    update_o;
    logic          update_valid_o, rbk_o, flush_o, stall_req_o, err_o;
    logic [AW-1:0] rbk_addr_o;
`ifdef BRANCH_STATS_EN
    logic [31:0]   stat_br_o, stat_mis_o;
`endif

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .id_branch_i    (id_branch_i),
        .state_i        (state_i),
        .id_target_i    (id_target_i),
        .id_pc4_i       (id_pc4_i),
        .ex_valid_i     (ex_valid_i),
        .ex_taken_i     (ex_taken_i),
        .update_o       (update_o),
        .update_valid_o (update_valid_o),
        .rbk_o          (rbk_o),
        .rbk_addr_o     (rbk_addr_o),
        .flush_o        (flush_o),
        .stall_req_o    (stall_req_o),
`ifdef BRANCH_STATS_EN
        .stat_br_o      (stat_br_o),
        .stat_mis_o     (stat_mis_o),
`endif
        .err_o          (err_o)
    );

    // Reference model: a plain queue of outstanding predictions.
    typedef struct {
        bit          pred;
        logic [31:0] alt;
    } ent_t;

    ent_t        q[$];
    bit          recovering;
    logic [1:0]  exp_upd;
    bit          exp_uv, exp_rbk, exp_flush, exp_err;
    logic [31:0] exp_addr;
    int          n_br, n_mis;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        q.delete();
        recovering = 0;
        exp_upd = 2'b11; exp_uv = 0; exp_rbk = 0; exp_flush = 0; exp_err = 0;
        exp_addr = '0; n_br = 0; n_mis = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".update"},  update_o, exp_upd);
        chk({tag, ".uvalid"},  update_valid_o, exp_uv);
        chk({tag, ".rbk"},     rbk_o, exp_rbk);
        chk({tag, ".flush"},   flush_o, exp_flush);
        chk({tag, ".err"},     err_o, exp_err);
        if (exp_rbk) chk({tag, ".rbk_addr"}, rbk_addr_o, exp_addr);
`ifdef BRANCH_STATS_EN
        chk({tag, ".stat_br"},  stat_br_o, n_br);
        chk({tag, ".stat_mis"}, stat_mis_o, n_mis);
`endif
    endtask

    // One clock cycle: drive inputs, check the combinational stall request,
    // advance the model, then check the registered outputs after the edge.
    task automatic step(input logic br, input logic [1:0] st, input logic [31:0] tgt,
                        input logic [31:0] pc4, input logic exv, input logic ext,
                        input logic stl);
        bit   pop, mis, push;
        int   s;
        ent_t e;
        id_branch_i = br; state_i = st; id_target_i = tgt; id_pc4_i = pc4;
        ex_valid_i = exv; ex_taken_i = ext; stall_i = stl;
        #1;
        pop  = exv && !stl && q.size() > 0;
        mis  = pop && (ext != q[0].pred);
        chk("stall_req", stall_req_o, br && q.size() == DEPTH && !(pop && !mis));
        if (exv && !stl && q.size() == 0) exp_err = 1;
        push = br && !stl && !recovering && !mis && (q.size() < DEPTH || pop);
        s = st;
        exp_uv = pop;
        if (pop) exp_upd = 2'(ext ? ((s == 3) ? 3 : s + 1) : ((s == 0) ? 0 : s - 1));
        exp_rbk = mis; exp_flush = mis;
        if (mis) begin
            exp_addr = q[0].alt;
            q.delete();
        end else if (pop) begin
            void'(q.pop_front());
        end
        if (push) begin
            e.pred = st[1];
            e.alt  = st[1] ? pc4 : tgt;
            q.push_back(e);
        end
        if (!stl) recovering = mis;
        if (pop) n_br++;
        if (mis) n_mis++;
        @(posedge clk); #1;
        check_outputs("step");
    endtask

    task automatic idle();
        step(0, 2'b00, 32'h0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        chk("reset.stall_req", stall_req_o, 1'b0);
        rst_i = 1'b1;
        @(posedge clk); #1;

        // Correct prediction at the strong-taken rail
        step(1, 2'b11, 32'h100, 32'h24, 0, 0, 0);
        step(0, 2'b11, 32'h0, 32'h0, 1, 1, 0);
        chk("tp1.update", update_o, 2'b11);
        chk("tp1.uvalid", update_valid_o, 1'b1);
        chk("tp1.rbk", rbk_o, 1'b0);

        // Mispredict: predicted taken, resolves not-taken
        step(1, 2'b10, 32'h200, 32'h40, 0, 0, 0);
        step(0, 2'b10, 32'h0, 32'h0, 1, 0, 0);
        chk("tp2.update", update_o, 2'b01);
        chk("tp2.rbk_addr", rbk_addr_o, 32'h40);
        chk("tp2.flush", flush_o, 1'b1);
        step(1, 2'b11, 32'h300, 32'h44, 0, 0, 0);   // wrong path, ignored
        chk("tp2.pulse_end", rbk_o, 1'b0);
        idle();

        // Saturation at both ends
        step(1, 2'b00, 32'h500, 32'h50, 0, 0, 0);
        step(0, 2'b00, 32'h0, 32'h0, 1, 0, 0);
        chk("tp3.sat_lo", update_o, 2'b00);
        step(1, 2'b11, 32'h600, 32'h60, 0, 0, 0);
        step(0, 2'b11, 32'h0, 32'h0, 1, 1, 0);
        chk("tp3.sat_hi", update_o, 2'b11);

        // Fill the queue, stall a third branch, then pop and push together
        step(1, 2'b11, 32'h700, 32'h70, 0, 0, 0);
        step(1, 2'b11, 32'h800, 32'h80, 0, 0, 0);
        step(1, 2'b11, 32'h900, 32'h90, 0, 0, 0);
        step(1, 2'b11, 32'h900, 32'h90, 1, 1, 0);

        // Older mispredicts while a push arrives: push dropped, RECOVER, IDLE
        step(1, 2'b11, 32'hA00, 32'hA0, 1, 0, 0);
        chk("tp5.rbk_addr", rbk_addr_o, 32'h80);
        idle();
        idle();

        // Resolve with nothing in flight: sticky error
        step(0, 2'b01, 32'h0, 32'h0, 1, 1, 0);
        chk("tp6.err", err_o, 1'b1);
        idle();
        idle();

        // Mispredict, then reset asynchronously during RECOVER
        step(1, 2'b01, 32'hB00, 32'hB0, 0, 0, 0);
        step(0, 2'b01, 32'h0, 32'h0, 1, 1, 0);
        id_branch_i = 0; ex_valid_i = 0; stall_i = 0;
        #1 rst_i = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #4 rst_i = 1'b1;
        @(posedge clk); #1;

        // Three pops, one mispredict (statistics when enabled)
        step(1, 2'b11, 32'hC00, 32'hC0, 0, 0, 0);
        step(1, 2'b00, 32'hD00, 32'hD0, 1, 1, 0);
        step(0, 2'b00, 32'h0, 32'h0, 1, 0, 0);
        step(1, 2'b10, 32'hE00, 32'hE0, 0, 0, 0);
        step(0, 2'b10, 32'h0, 32'h0, 1, 0, 0);
`ifdef BRANCH_STATS_EN
        chk("stats.br", stat_br_o, 32'd3);
        chk("stats.mis", stat_mis_o, 32'd1);
`endif
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 1) == 1),
                 2'($urandom_range(0, 3)),
                 $urandom, $urandom,
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the 2-bit branch predictor across the ID→EX window.
- Records each prediction made in ID in a small in-flight queue, pops it when the branch resolves in EX, and issues the predictor update.
- On a misprediction, issues a rollback PC and a pipeline flush.
- Sits between decode/execute control and the predictor. It generates the predictor's update value and the rollback request; the PC mux selects its rollback address.

Parameters:
- DEPTH, 2: in-flight queue entries (power of two, ≥2).
- AW, 32: PC/address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- stall_i  in  1  pipeline hold; no push and no pop while high.
- id_branch_i  in  1  a conditional branch is in ID this cycle.
- state_i  in  2  current predictor counter (00 SNT, 01 WNT, 10 WT, 11 ST).
- id_target_i  in  AW  branch target computed in ID.
- id_pc4_i  in  AW  fall-through PC of the ID branch.
- ex_valid_i  in  1  the oldest branch resolves in EX this cycle.
- ex_taken_i  in  1  actual outcome of the resolving branch.
- update_o  out  2  next predictor counter.
- update_valid_o  out  1  predictor must load update_o.
- rbk_o  out  1  misprediction; PC mux selects rbk_addr_o.
- rbk_addr_o  out  AW  correct-path PC.
- flush_o  out  1  flush IF/ID and ID/EX.
- stall_req_o  out  1  queue full and a new ID branch is waiting.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, any cycle, including mid-recovery):
  - Queue emptied; FSM goes to IDLE.
  - Outputs: update_o=11, update_valid_o=0, rbk_o=0, rbk_addr_o=0, flush_o=0, err_o=0.
- Push: occurs when id_branch_i & ~stall_i & ~full & FSM≠RECOVER. The entry stores:
  - pred = state_i[1];
  - alt = pred ? id_pc4_i : id_target_i.
- Pop: occurs when ex_valid_i & ~stall_i & ~empty. Pops the oldest entry.
  - update_o = saturating counter: taken → min(state_i+1, 3); not taken → max(state_i−1, 0). Computed in 3-bit width, then clamped.
  - update_valid_o=1 for exactly one cycle.
- Latency: all outputs are registered and valid in the cycle after the pop.
- Mispredict (ex_taken_i ≠ entry.pred):
  - Next cycle: rbk_o=1, flush_o=1, rbk_addr_o=entry.alt, all for one cycle.
  - All remaining (younger, wrong-path) entries are discarded.
- Simultaneous push and pop:
  - If the pop is correctly predicted: both happen and occupancy is unchanged.
  - If the pop mispredicts: the push is dropped.
- FSM states:
  - IDLE (empty): push → TRACK.
  - TRACK (1..DEPTH−1 entries): push without pop → FULL when count reaches DEPTH; pop to empty → IDLE; mispredict → RECOVER.
  - FULL: stall_req_o = id_branch_i; pop → TRACK; mispredict → RECOVER.
  - RECOVER: lasts one cycle; id_branch_i is ignored (wrong path); then → IDLE.
- Boundary and error cases:
  - ex_valid_i while empty: no pop, no outputs, err_o set (cleared only by reset).
  - Push while full: not performed; stall_req_o covers it.
  - Pointers wrap modulo DEPTH.
  - stall_i high freezes the queue, FSM and err_o. One-cycle pulse outputs still drop to 0.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds output ports stat_br_o[31:0] and stat_mis_o[31:0].
  - stat_br_o counts pops; stat_mis_o counts mispredicts.
  - Both reset to 0, saturate at 0xFFFFFFFF, and update in the same cycle as update_valid_o.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package branch_pkg holds:
  - counter encodings SNT/WNT/WT/ST;
  - FSM state enum IDLE/TRACK/FULL/RECOVER;
  - PC-select codes PCSEL_PC4=00, PCSEL_TGT=01, PCSEL_RBK=10.
- Sub-module branch_inflight_fifo: DEPTH×(1+AW) FIFO with push, pop, flush_all, full, empty and count.

Test Plan:
- Reset; state_i=11; branch at ID (target 0x100, pc4 0x24); resolve taken → next cycle update_o=11, update_valid_o=1, rbk_o=0, flush_o=0.
- state_i=10; ID branch (target 0x200, pc4 0x40); resolve not-taken → update_o=01, rbk_o=1, rbk_addr_o=0x40, flush_o=1 for one cycle; the following cycle's id_branch_i is ignored.
- state_i=00, resolve not-taken → update_o=00; state_i=11, resolve taken → update_o=11 (saturation at both ends).
- Push 2 branches without a pop → FULL; a third id_branch_i gives stall_req_o=1; then a correct pop → stall_req_o=0 and the push is accepted in the same cycle.
- Two entries in flight; the older mispredicts while a new push arrives in the same cycle → queue empty, push dropped, FSM enters RECOVER then IDLE.
- ex_valid_i with the queue empty → err_o=1 and held; assert rst_i low mid-RECOVER → all outputs return to their reset values asynchronously. With BRANCH_STATS_EN defined, after 3 pops including 1 mispredict: stat_br_o=3, stat_mis_o=1.
